// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control FSM: state sequencing, per-state datapath controls,
// memory wait/timeout supervision and sticky fault reporting.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       error,
  output logic [1:0] error_code,
  output logic [3:0] state
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
  err_e          code_q, code_d;
  logic          mem_wait;
  logic          timeout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    error_d  = error_q;
    code_d   = code_q;
    mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
               && !mem_ready;
    timeout  = mem_wait && (cnt_q == CNT_LAST);

    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_ERROR;
            code_d  = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase

    // mem_ready on the final allowed wait cycle already took the normal branch above
    if (timeout) begin
      state_d = S_ERROR;
      code_d  = ERR_TIMEOUT;
    end
    if (state_d == S_ERROR) error_d = 1'b1;
    if (mem_wait && (state_d == state_q)) cnt_d = cnt_q + CW'(1);

    instr_done = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    AdrSrc    = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  assign state      = state_q;
  assign error      = error_q;
  assign error_code = code_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, is the number of consecutive memory-wait cycles with mem_ready low before a timeout error.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction opcode from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory has completed the current request this cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  write request qualifier; valid only with mem_req.
REQ-009 AdrSrc  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-010 PCWrite, IRWrite, RegWrite  output  1 each  register write enables.
REQ-011 ALUSrcA  output  2  operand A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-012 ALUSrcB  output  2  operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = live ALU result.
REQ-014 ALUOp  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = decode func fields.
REQ-015 instr_done  output  1  one-cycle pulse when an instruction completes.
REQ-016 error  output  1  sticky fault flag.
REQ-017 error_code  output  2  fault type: 00 = none, 01 = illegal opcode, 10 = memory timeout.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111; any other opcode is illegal.
REQ-020 State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, ERROR 15.
REQ-021 Outputs not listed for a state are 0.
REQ-022 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready (same cycle); stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut); next state is MEMADR for lw/sw, EXECR, EXECI, BEQ or JAL by opcode; illegal opcode goes to ERROR with code 01.
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD for lw, MEMWRITE for sw.
REQ-025 MEMREAD: mem_req=1, AdrSrc=1; go to MEMWB on mem_ready. MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-026 MEMWRITE: mem_req=1, mem_we=1, AdrSrc=1; go to FETCH on mem_ready.
REQ-027 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-029 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero (same cycle); next state FETCH.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB, which writes oldPC+4 to rd.
REQ-031 instr_done=1 in any cycle whose next state is FETCH, excluding stalled FETCH cycles.
REQ-032 Wait counter: increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0; clears on mem_ready=1 or on any state change.
REQ-033 Timeout: when the counter reaches MEM_TIMEOUT-1 and mem_ready=0, the next state is ERROR with code 10; mem_ready=1 in that same cycle wins, with a normal transition.
REQ-034 ERROR: all control outputs 0, error=1; holds until reset; error_code is latched on entry.
REQ-035 mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-036 Latency in cycles, assuming zero-wait memory: R/I/jal = 4, beq = 3, lw = 5, sw = 4.

Reset
REQ-037 On reset=1 at a clock edge: state=FETCH, counter=0, error=0, error_code=00; this overrides any in-flight access or ERROR.
REQ-038 Reset values of the registered outputs are as above; in the following cycle the combinational outputs are those of FETCH.

Verification
REQ-039 Reset, then R-type with mem_ready tied 1 -> states 0,1,6,8,0; RegWrite=1 in state 8 only; instr_done pulses once.
REQ-040 lw, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1, AdrSrc=1; then MEMWB with ResultSrc=01.
REQ-041 beq with zero=1, then with zero=0 -> PCWrite=1, then PCWrite=0, in state 9; both return to FETCH.
REQ-042 Opcode 1111111 in DECODE -> ERROR, error=1, error_code=01, state=15 held; reset returns to FETCH.
REQ-043 MEM_TIMEOUT=4, mem_ready low in FETCH -> ERROR after 4 cycles with code 10; mem_ready=1 on the 4th cycle -> DECODE instead.
REQ-044 Reset asserted mid-MEMWRITE with mem_ready=0 -> next cycle state=0, mem_we=0, counter=0.
